cordic_hyp_engine: RTL and testbench
====================================

CORDIC_HYP_ENGINE -- requirements
Module: cordic_hyp_engine

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  engine can accept an operand.
- mode  input  1  0 = rotation, 1 = vectoring; sampled on accept.
- x_in  input  32  signed Q8.24 operand.
- y_in  input  32  signed Q8.24 operand.
- z_in  input  32  signed Q8.24 operand.
- lut_index  output  5  signed index driven to the atanh lookup table.
- lut_value  input  32  signed Q8.24 atanh constant returned combinationally for lut_index.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- x_out  output  32  registered signed Q8.24 result.
- y_out  output  32  registered signed Q8.24 result.
- z_out  output  32  registered signed Q8.24 result.
- busy  output  1  high in RUN or DONE.

Function
REQ-003 FSM states SHALL be IDLE, RUN and DONE.
- IDLE to RUN on in_valid && in_ready.
- RUN to DONE after step 18.
- DONE to IDLE on out_ready.
REQ-004 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 On accept, x_in, y_in, z_in and mode SHALL be captured into working registers X, Y, Z, and the step counter s SHALL be cleared to 0.
REQ-006 In RUN, lut_index SHALL be combinational from s:
- s = 0..3 gives -3..0.
- s = 4..7 gives 1..4.
- s = 8 gives 4.
- s = 9..17 gives 5..13.
- s = 18 gives 13.
- Outside RUN, lut_index SHALL be 0.
REQ-007 The direction d SHALL be:
- rotation: d = +1 if Z >= 0, else -1.
- vectoring: d = +1 if Y < 0, else -1.
REQ-008 Each RUN cycle SHALL perform one iteration with i = lut_index:
- shift term: for i <= 0, S(v) = v - (v >>> (2 - i)); for i >= 1, S(v) = v >>> i.
- X <= X + d*S(Y); Y <= Y + d*S(X); Z <= Z - d*lut_value.
- all right-hand sides use pre-update values.
REQ-009 All shifts SHALL be arithmetic with truncation toward minus infinity; add and subtract SHALL be 32-bit two's complement wrapping with no saturation.
REQ-010 Exactly 19 iterations SHALL run.
- Relative to accept edge E0, iterations occur at E1..E19.
- out_valid SHALL be 1 in the cycle after E19.
REQ-011 x_out, y_out and z_out SHALL equal X, Y, Z after the final iteration, SHALL be gain-uncompensated, and SHALL hold stable while out_valid && !out_ready.
REQ-012 in_valid SHALL be ignored outside IDLE; the block SHALL NOT accept a new operand in the same cycle as a result handshake.
REQ-013 Back-to-back operation with in_valid = out_ready = 1 SHALL give one result per 21 cycles.

Reset
REQ-014 Asserting rst SHALL immediately force:
- state = IDLE, s = 0.
- X, Y, Z and all outputs = 0.
- out_valid = 0, busy = 0, in_ready = 1 (once rst deasserts).
- lut_index = 0.
REQ-015 Reset mid-RUN or mid-DONE SHALL discard the operation with no partial result; the next accepted operand SHALL complete normally.

Verification
REQ-016 Rotation: x_in = 0x01000000, y_in = 0, z_in = 0x00800000 (0.5) -> out_valid 19 cycles after accept; y_out/x_out = tanh(0.5) = 0.4621 within 2^-10; |z_out| <= 2^-11; bit-exact to the reference model.
REQ-017 Vectoring: x_in = 0x01000000, y_in = 0x00800000, z_in = 0 -> z_out = 0x008C9F54 (atanh 0.5) within 2^-10; |y_out| <= 2^-11.
REQ-018 Schedule check: monitor lut_index during RUN -> sequence -3,-2,-1,0,1,2,3,4,4,5,...,13,13 (19 entries), then 0.
REQ-019 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle.
REQ-020 Reset at RUN step 7 -> out_valid, busy, lut_index and outputs 0 immediately; a following operand gives a result bit-identical to an uninterrupted run.
REQ-021 Streaming: 10 random operands with in_valid = out_ready = 1 -> results in order, 21-cycle period, bit-exact to the model, including wraparound for |x_in| near 0x7F000000.

Source files
------------

// File: rtl/cordic_hyp_engine.sv
// Hyperbolic CORDIC engine, one iteration per clock.
// Uses the extended schedule with four negative-index iterations for range
// expansion, then indices 1..13 with 4 and 13 repeated. lut_value comes from
// an external atanh table that is addressed combinationally by lut_index.
// Results are gain-uncompensated.

// Shift term for one operand: i <= 0 gives v - (v >>> (2 - i)), i >= 1 gives v >>> i.
module cordic_hyp_shift (
    input  logic [31:0] v,
    input  logic        neg,
    input  logic [4:0]  sh,
    output logic [31:0] s
);
    logic [31:0] shifted;

    // Arithmetic shift, so the result is truncated toward minus infinity.
    always_comb begin
        shifted = $signed(v) >>> sh;
        s       = neg ? (v - shifted) : shifted;
    end
endmodule

module cordic_hyp_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic [4:0]  lut_index,
    input  logic [31:0] lut_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST_STEP = 5'd18;

    state_t      state, state_nxt;
    logic [4:0]  s;
    logic        mode_r;
    logic [31:0] xr, yr, zr;
    logic [31:0] x_nxt, y_nxt, z_nxt;
    logic [31:0] sx, sy;
    logic        accept, last, neg, dpos;
    logic [4:0]  sh;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (s == LAST_STEP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (s == LAST_STEP) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration schedule: -3..4, 4 repeated, 5..13, 13 repeated; 0 when not running.
    always_comb begin
        lut_index = 5'd0;
        if (state == RUN) begin
            if (s <= 5'd7)       lut_index = s - 5'd3;
            else if (s == 5'd8)  lut_index = 5'd4;
            else if (s <= 5'd17) lut_index = s - 5'd4;
            else                 lut_index = 5'd13;
        end
    end

    // Negative/zero indices use the range-expansion form with shift 2 - i.
    always_comb begin
        neg = lut_index[4] || (lut_index == 5'd0);
        sh  = neg ? (5'd2 - lut_index) : lut_index;
    end

    cordic_hyp_shift u_shx (.v(xr), .neg(neg), .sh(sh), .s(sx));
    cordic_hyp_shift u_shy (.v(yr), .neg(neg), .sh(sh), .s(sy));

    // Rotation drives Z toward 0; vectoring drives Y toward 0.
    always_comb begin
        dpos  = mode_r ? yr[31] : ~zr[31];
        x_nxt = dpos ? (xr + sy) : (xr - sy);
        y_nxt = dpos ? (yr + sx) : (yr - sx);
        z_nxt = dpos ? (zr - lut_value) : (zr + lut_value);
    end

    // Working registers and step counter; result registers load on the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s      <= 5'd0;
            mode_r <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else if (accept) begin
            s      <= 5'd0;
            mode_r <= mode;
            xr     <= x_in;
            yr     <= y_in;
            zr     <= z_in;
        end else if (state == RUN) begin
            xr <= x_nxt;
            yr <= y_nxt;
            zr <= z_nxt;
            s  <= last ? 5'd0 : (s + 5'd1);
            if (last) begin
                x_out <= x_nxt;
                y_out <= y_nxt;
                z_out <= z_nxt;
            end
        end
    end
endmodule

// File: tb/tb_cordic_hyp_engine.sv
// Self-checking bench for cordic_hyp_engine: table vectors, schedule,
// backpressure, mid-run reset and streaming with a scoreboard queue.
module tb_cordic_hyp_engine;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1;
    logic [31:0] x_in = '0, y_in = '0, z_in = '0;
    logic        in_ready, out_valid, busy;
    logic [4:0]  lut_index;
    logic [31:0] lut_value, x_out, y_out, z_out;

    cordic_hyp_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .lut_index(lut_index), .lut_value(lut_value),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
        .z_out(z_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // atanh constants in Q8.24, rounded to nearest.
    function automatic logic [31:0] atanh_q(input int i);
        real t;
        int  q;
        t = (i <= 0) ? (1.0 - $pow(2.0, real'(i - 2))) : $pow(2.0, real'(-i));
        q = $rtoi($atanh(t) * 16777216.0 + 0.5);
        return q;
    endfunction

    logic signed [4:0] li;
    assign li = lut_index;
    always_comb lut_value = atanh_q(int'(li));

    int sched [19] = '{-3, -2, -1, 0, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};

    // Reference model.
    task automatic model(input bit m, input logic [31:0] xi, yi, zi,
                         output logic [31:0] xo, yo, zo);
        logic signed [31:0] x, y, z, tx, ty, lv;
        int i;
        bit d;
        x = xi; y = yi; z = zi;
        for (int k = 0; k < 19; k++) begin
            i  = sched[k];
            lv = atanh_q(i);
            if (i <= 0) begin
                tx = x - (x >>> (2 - i));
                ty = y - (y >>> (2 - i));
            end else begin
                tx = x >>> i;
                ty = y >>> i;
            end
            d = m ? (y < 0) : (z >= 0);
            if (d) begin x = x + ty; y = y + tx; z = z - lv; end
            else   begin x = x - ty; y = y - tx; z = z + lv; end
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkr(input string name, input real err, input real lim);
        tests++;
        if (!(err <= lim)) begin
            fails++;
            $display("FAIL %s: error %f exceeds %f", name, err, lim);
        end
    endtask

    typedef struct { logic [31:0] x, y, z; } res_t;
    res_t sbq[$];
    int   rcyc[$];
    bit   sb_en = 1'b0;

    // Scoreboard: compare every result handshake against the queued expectation.
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_result: got %h %h %h expected none", x_out, y_out, z_out);
            end else begin
                res_t e;
                e = sbq.pop_front();
                chk("sb_x", x_out, e.x);
                chk("sb_y", y_out, e.y);
                chk("sb_z", z_out, e.z);
                rcyc.push_back(cyc);
            end
        end
    end

    task automatic send(input bit m, input logic [31:0] x, y, z, input bit push);
        int n;
        res_t e;
        mode = m; x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready %b expected 1", in_ready);
        end
        if (push) begin
            model(m, x, y, z, e.x, e.y, e.z);
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] x, y, z);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("done_timeout", {31'd0, out_valid}, 32'd1);
        x = x_out; y = y_out; z = z_out;
    endtask

    typedef struct { bit m; logic [31:0] x, y, z, ex, ey, ez; } vec_t;
    vec_t vt[6];

    initial begin
        logic [31:0] ax, ay, az, hx, hy, hz;
        real r;

        vt[0] = '{1'b0, 32'h01000000, 32'h00000000, 32'h00800000, '0, '0, '0};
        vt[1] = '{1'b1, 32'h01000000, 32'h00800000, 32'h00000000, '0, '0, '0};
        vt[2] = '{1'b0, 32'h00C00000, 32'h00200000, 32'hFF800000, '0, '0, '0};
        vt[3] = '{1'b1, 32'h02000000, 32'hFF000000, 32'h00400000, '0, '0, '0};
        vt[4] = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, '0, '0, '0};
        vt[5] = '{1'b0, 32'h7F000000, 32'h7F000000, 32'h01000000, '0, '0, '0};
        for (int k = 0; k < 6; k++) model(vt[k].m, vt[k].x, vt[k].y, vt[k].z, vt[k].ex, vt[k].ey, vt[k].ez);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_lut_index", {27'd0, lut_index}, 32'd0);
        chk("rst_x_out", x_out, 32'd0);

        // Table-driven vectors
        for (int k = 0; k < 6; k++) begin
            send(vt[k].m, vt[k].x, vt[k].y, vt[k].z, 1'b0);
            wait_done(ax, ay, az);
            chk($sformatf("vec%0d_x", k), ax, vt[k].ex);
            chk($sformatf("vec%0d_y", k), ay, vt[k].ey);
            chk($sformatf("vec%0d_z", k), az, vt[k].ez);
            if (k == 0) begin
                r = $itor($signed(ay)) / $itor($signed(ax)) - $tanh(0.5);
                chkr("rot_tanh", (r < 0.0) ? -r : r, 1.0 / 1024.0);
                r = $itor($signed(az)) / 16777216.0;
                chkr("rot_zres", (r < 0.0) ? -r : r, 1.0 / 2048.0);
            end
            if (k == 1) begin
                r = ($itor($signed(az)) - $itor(32'h008C9F54)) / 16777216.0;
                chkr("vec_atanh", (r < 0.0) ? -r : r, 1.0 / 1024.0);
                r = $itor($signed(ay)) / 16777216.0;
                chkr("vec_yres", (r < 0.0) ? -r : r, 1.0 / 2048.0);
            end
            @(posedge clk); #1;
        end

        // Schedule and latency
        sb_en = 1'b1;
        send(1'b0, 32'h01000000, 32'h0, 32'h00800000, 1'b1);
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            chk($sformatf("sched%0d", k), {{27{li[4]}}, lut_index}, sched[k]);
        end
        @(negedge clk);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_lut_index", {27'd0, lut_index}, 32'd0);
        @(posedge clk); #1;

        // Backpressure in DONE
        out_ready = 1'b0;
        send(1'b1, 32'h00C00000, 32'h00400000, 32'h0, 1'b1);
        wait_done(hx, hy, hz);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 in_valid = k[0];
            x_in = 32'h12345678;
            @(negedge clk);
            chk("bp_x_stable", x_out, hx);
            chk("bp_z_stable", z_out, hz);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
        chk("bp_release_ov", {31'd0, out_valid}, 32'd0);

        // Reset at RUN step 7, then a clean rerun of the same operand
        send(1'b0, 32'h01400000, 32'hFFC00000, 32'h00A00000, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_lut_index", {27'd0, lut_index}, 32'd0);
        chk("mid_rst_y_out", y_out, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        send(1'b0, 32'h01400000, 32'hFFC00000, 32'h00A00000, 1'b1);

        // Streaming: 10 random operands, back-to-back
        begin
            int n;
            n = 0;
            while (sbq.size() != 0 && n < 200) begin @(posedge clk); n++; end
        end
        @(posedge clk); #1;
        rcyc.delete();
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] rx, ry, rz;
            rx = $urandom_range(32'h01FFFFFF, 0);
            ry = $urandom_range(32'h01FFFFFF, 0) - 32'h01000000;
            rz = $urandom_range(32'h01FFFFFF, 0) - 32'h01000000;
            if (k % 3 == 0) rx = 32'h7F000000 - $urandom_range(32'h0000FFFF, 0);
            if (k % 3 == 1) rx = 32'h81000000 + $urandom_range(32'h0000FFFF, 0);
            send(k[0], rx, ry, rz, 1'b1);
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (sbq.size() != 0 && n < 400) begin @(posedge clk); n++; end
        end
        chk("sb_drained", sbq.size(), 32'd0);
        chk("stream_count", rcyc.size(), 32'd10);
        for (int k = 1; k < rcyc.size(); k++) chk($sformatf("period%0d", k), rcyc[k] - rcyc[k-1], 32'd21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
